// File: rtl/seven_seg_pkg.sv
// Segment patterns and bit positions for the single-digit
// seven-segment decoder; patterns are stored active-low.
package seven_seg_pkg;

  localparam int unsigned SEG_A_BIT = 0;
  localparam int unsigned SEG_B_BIT = 1;
  localparam int unsigned SEG_C_BIT = 2;
  localparam int unsigned SEG_D_BIT = 3;
  localparam int unsigned SEG_E_BIT = 4;
  localparam int unsigned SEG_F_BIT = 5;
  localparam int unsigned SEG_G_BIT = 6;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Dash lights segment g only.
  localparam logic [6:0] SEG_DASH =
    7'h7F ^ (7'h01 << SEG_G_BIT);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seven_seg_if.sv
// Digit value in, segment pattern out; one bundle
// per displayed digit.
interface seven_seg_if #(
  parameter int VAL_W = 32
);
  logic [VAL_W-1:0] value;
  logic [6:0]       hex;

  modport master (output value, input hex);
  modport slave  (input value, output hex);
endinterface

// File: rtl/seven_seg_lut.sv
// Nibble to raw active-low segment pattern; a set
// range_err overrides the nibble with a dash.
module seven_seg_lut
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       range_err,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (!range_err) begin
      case (nibble)
        4'h0:    seg = SEG_0;
        4'h1:    seg = SEG_1;
        4'h2:    seg = SEG_2;
        4'h3:    seg = SEG_3;
        4'h4:    seg = SEG_4;
        4'h5:    seg = SEG_5;
        4'h6:    seg = SEG_6;
        4'h7:    seg = SEG_7;
        4'h8:    seg = SEG_8;
        4'h9:    seg = SEG_9;
        4'hA:    seg = SEG_A;
        4'hB:    seg = SEG_B;
        4'hC:    seg = SEG_C;
        4'hD:    seg = SEG_D;
        4'hE:    seg = SEG_E;
        default: seg = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg.sv
// Registered single-digit decoder: range check, hex
// masking, polarity and one output register.
module seven_seg
  import seven_seg_pkg::*;
#(
  parameter int VAL_W      = 32,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_EN     = 1'b1
) (
  input  logic             CLK_50M,
  input  logic             RSTn,
  input  logic [VAL_W-1:0] value,
  output logic [6:0]       hex
);

  localparam logic [6:0] RST_PAT =
    ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  logic       over_range;
  logic       hex_digit;
  logic       range_err;
  logic [6:0] raw;
  logic [6:0] hex_d;
  logic [6:0] hex_q;

  // Whole word compared so 16 never aliases to 0.
  always_comb begin
    over_range = value > VAL_W'(15);
    hex_digit  = value[3:0] > 4'd9;
    range_err  = over_range | (hex_digit & !HEX_EN);
  end

  seven_seg_lut u_lut (
    .nibble    (value[3:0]),
    .range_err (range_err),
    .seg       (raw)
  );

  always_comb begin
    hex_d = raw;
    if (!ACTIVE_LOW) hex_d = ~raw;
  end

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) hex_q <= RST_PAT;
    else       hex_q <= hex_d;
  end

  assign hex = hex_q;

endmodule

// File: tb/tb_seven_seg.sv
// Scoreboard bench for seven_seg: default, HEX_EN=0,
// ACTIVE_LOW=0 and a tens-digit instance side by side.
module tb_seven_seg;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    string       nm;
    logic [6:0]  ea;
    logic [6:0]  eb;
    logic [6:0]  ec;
    logic [6:0]  et;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] v;
    logic [31:0] vt;
    logic [6:0]  ea;
    logic [6:0]  eb;
    logic [6:0]  ec;
    logic [6:0]  et;
  } vec_t;

  exp_t q[$];
  vec_t vecs[$];

  seven_seg_if #(.VAL_W(32)) bus_a ();
  seven_seg_if #(.VAL_W(32)) bus_b ();
  seven_seg_if #(.VAL_W(32)) bus_c ();
  seven_seg_if #(.VAL_W(32)) bus_t ();

  seven_seg #(.VAL_W(32), .ACTIVE_LOW(1'b1),
              .HEX_EN(1'b1)) u_a (
    .CLK_50M (clk), .RSTn (rst_n),
    .value (bus_a.value), .hex (bus_a.hex));

  seven_seg #(.VAL_W(32), .ACTIVE_LOW(1'b1),
              .HEX_EN(1'b0)) u_b (
    .CLK_50M (clk), .RSTn (rst_n),
    .value (bus_b.value), .hex (bus_b.hex));

  seven_seg #(.VAL_W(32), .ACTIVE_LOW(1'b0),
              .HEX_EN(1'b1)) u_c (
    .CLK_50M (clk), .RSTn (rst_n),
    .value (bus_c.value), .hex (bus_c.hex));

  seven_seg #(.VAL_W(32), .ACTIVE_LOW(1'b1),
              .HEX_EN(1'b1)) u_t (
    .CLK_50M (clk), .RSTn (rst_n),
    .value (bus_t.value), .hex (bus_t.hex));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [6:0] act,
                     input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    bus_a.value = v.v;
    bus_b.value = v.v;
    bus_c.value = v.v;
    bus_t.value = v.vt;
    e.nm = v.nm;
    e.ea = v.ea;
    e.eb = v.eb;
    e.ec = v.ec;
    e.et = v.et;
    q.push_back(e);
  endtask

  task automatic add(input string nm,
                     input logic [31:0] v,
                     input logic [31:0] vt,
                     input logic [6:0] ea,
                     input logic [6:0] eb,
                     input logic [6:0] ec,
                     input logic [6:0] et);
    vec_t x;
    x.nm = nm; x.v = v; x.vt = vt;
    x.ea = ea; x.eb = eb; x.ec = ec; x.et = et;
    vecs.push_back(x);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d pending, required 0",
               nm, q.size());
      q.delete();
    end
  endtask

  // Monitor: output registered at posedge, sampled 2 later.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.nm, "/a"}, bus_a.hex, e.ea);
      chk({e.nm, "/b"}, bus_b.hex, e.eb);
      chk({e.nm, "/c"}, bus_c.hex, e.ec);
      chk({e.nm, "/t"}, bus_t.hex, e.et);
    end
  end

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_a.value = 32'd5;
    bus_b.value = 32'd5;
    bus_c.value = 32'd5;
    bus_t.value = 32'd0;

    add("d0", 0, 0, 7'h40, 7'h40, 7'h3F, 7'h40);
    add("d1", 1, 0, 7'h79, 7'h79, 7'h06, 7'h40);
    add("d2", 2, 0, 7'h24, 7'h24, 7'h5B, 7'h40);
    add("d3", 3, 0, 7'h30, 7'h30, 7'h4F, 7'h40);
    add("d4", 4, 0, 7'h19, 7'h19, 7'h66, 7'h40);
    add("d5", 5, 0, 7'h12, 7'h12, 7'h6D, 7'h40);
    add("d6", 6, 0, 7'h02, 7'h02, 7'h7D, 7'h40);
    add("d7", 7, 0, 7'h78, 7'h78, 7'h07, 7'h40);
    add("d8", 8, 0, 7'h00, 7'h00, 7'h7F, 7'h40);
    add("d9", 9, 0, 7'h10, 7'h10, 7'h6F, 7'h40);
    add("hA", 10, 0, 7'h08, 7'h3F, 7'h77, 7'h40);
    add("hB", 11, 0, 7'h03, 7'h3F, 7'h7C, 7'h40);
    add("hC", 12, 0, 7'h46, 7'h3F, 7'h39, 7'h40);
    add("hD", 13, 0, 7'h21, 7'h3F, 7'h5E, 7'h40);
    add("hE", 14, 0, 7'h06, 7'h3F, 7'h79, 7'h40);
    add("hF", 15, 0, 7'h0E, 7'h3F, 7'h71, 7'h40);
    add("r16", 16, 0, 7'h3F, 7'h3F, 7'h40, 7'h40);
    add("r99", 99, 0, 7'h3F, 7'h3F, 7'h40, 7'h40);
    add("r256", 256, 0, 7'h3F, 7'h3F, 7'h40, 7'h40);
    add("rmax", 32'hFFFF_FFFF, 0,
        7'h3F, 7'h3F, 7'h40, 7'h40);
    add("s42", 2, 4, 7'h24, 7'h24, 7'h5B, 7'h19);

    repeat (3) @(negedge clk);
    chk("rst/a", bus_a.hex, 7'h7F);
    chk("rst/b", bus_b.hex, 7'h7F);
    chk("rst/c", bus_c.hex, 7'h00);
    chk("rst/t", bus_t.hex, 7'h7F);

    rst_n = 1'b1;
    add("rel5", 5, 0, 7'h12, 7'h12, 7'h6D, 7'h40);
    v = vecs.pop_back();
    drive(v);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
    end
    drain("sweep_drain");

    @(negedge clk);
    add("pre7", 7, 7, 7'h78, 7'h78, 7'h07, 7'h78);
    v = vecs.pop_back();
    drive(v);
    drain("pre7_drain");

    // Pulse reset between edges, away from both clock edges.
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("arst/a", bus_a.hex, 7'h7F);
    chk("arst/b", bus_b.hex, 7'h7F);
    chk("arst/c", bus_c.hex, 7'h00);
    chk("arst/t", bus_t.hex, 7'h7F);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("hold/a", bus_a.hex, 7'h7F);
    add("post7", 7, 7, 7'h78, 7'h78, 7'h07, 7'h78);
    v = vecs.pop_back();
    drive(v);
    drain("post7_drain");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
